// File: rtl/linear_layer_srl_fifo_ac.sv
// Shift-register-LUT FIFO with read/write handshake, occupancy count, almost-full flag
// and an optional registered output stage that adds one word of capacity.
module linear_layer_srl_fifo_ac #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16,
    parameter int AF_MARGIN  = 2,
    parameter int OUT_REG    = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  if_full_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_almost_full,
    output logic                  if_empty_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic [ADDR_WIDTH:0]   if_num_data_valid
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] MARGIN_C = (ADDR_WIDTH+1)'(AF_MARGIN);

    logic [DATA_WIDTH-1:0] entries [DEPTH];
    logic [ADDR_WIDTH:0]   cnt;
    logic [ADDR_WIDTH:0]   free_slots;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] head;
    logic                  wr_fire;
    logic                  rd_fire;
    logic                  srl_pop;
    logic                  out_vld;

    assign if_full_n  = (cnt != DEPTH_C);
    assign wr_fire    = if_write & if_write_ce & if_full_n;
    assign rd_fire    = if_read & if_read_ce & if_empty_n;

    // Head sits at cnt-1; at cnt=DEPTH the low bits wrap to 0 so the subtract lands on DEPTH-1.
    assign rd_addr    = cnt[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
    assign head       = entries[rd_addr];

    assign free_slots        = DEPTH_C - cnt;
    assign if_almost_full    = (free_slots <= MARGIN_C);
    assign if_num_data_valid = cnt + {{ADDR_WIDTH{1'b0}}, out_vld};

    // Storage: plain shift chain, no reset so it maps onto SRL primitives.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            entries[0] <= if_din;
            for (int i = 1; i < DEPTH; i++) begin
                entries[i] <= entries[i-1];
            end
        end
    end

    // A simultaneous push and pop leaves cnt, and therefore the head address, unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (wr_fire && !srl_pop) begin
            cnt <= cnt + (ADDR_WIDTH+1)'(1);
        end else if (!wr_fire && srl_pop) begin
            cnt <= cnt - (ADDR_WIDTH+1)'(1);
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] out_data;

            // Refill the output register whenever it is empty or being consumed.
            assign srl_pop = (cnt != '0) && (!out_vld || rd_fire);

            always_ff @(posedge clk) begin
                if (reset) begin
                    out_vld  <= 1'b0;
                    out_data <= '0;
                end else if (srl_pop) begin
                    out_vld  <= 1'b1;
                    out_data <= head;
                end else if (rd_fire) begin
                    out_vld  <= 1'b0;
                end
            end

            assign if_empty_n = out_vld;
            assign if_dout    = out_data;
        end else begin : g_comb_read
            assign srl_pop    = rd_fire;
            assign out_vld    = 1'b0;
            assign if_empty_n = (cnt != '0);
            assign if_dout    = head;
        end
    endgenerate

endmodule

// File: tb/tb_linear_layer_srl_fifo_ac.sv
// Bench for linear_layer_srl_fifo_ac: two instances (combinational and registered read)
// share one stimulus stream; a scoreboard queue per instance checks the popped data order.
module tb_linear_layer_srl_fifo_ac;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AFM   = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wce = 1'b0, w = 1'b0, rce = 1'b0, r = 1'b0;
    logic [DW-1:0] din = '0;

    logic          full_n  [2];
    logic          af      [2];
    logic          empty_n [2];
    logic [DW-1:0] dout    [2];
    logic [AW:0]   num     [2];

    int            mcnt [2];
    bit            mov  [2];
    logic [DW-1:0] exp0 [$];
    logic [DW-1:0] exp1 [$];
    int            passed = 0;
    int            total  = 0;

    always #5 clk = ~clk;

    linear_layer_srl_fifo_ac #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
                               .AF_MARGIN(AFM), .OUT_REG(0)) dut0 (
        .clk(clk), .reset(reset), .if_full_n(full_n[0]), .if_write_ce(wce),
        .if_write(w), .if_din(din), .if_almost_full(af[0]), .if_empty_n(empty_n[0]),
        .if_read_ce(rce), .if_read(r), .if_dout(dout[0]), .if_num_data_valid(num[0]));

    linear_layer_srl_fifo_ac #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
                               .AF_MARGIN(AFM), .OUT_REG(1)) dut1 (
        .clk(clk), .reset(reset), .if_full_n(full_n[1]), .if_write_ce(wce),
        .if_write(w), .if_din(din), .if_almost_full(af[1]), .if_empty_n(empty_n[1]),
        .if_read_ce(rce), .if_read(r), .if_dout(dout[1]), .if_num_data_valid(num[1]));

    task automatic chk(input string name, input int d, input logic [63:0] act,
                       input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, act, req, $time);
    endtask

    // Flags expected from the model's occupancy: SRL words plus the output-register word.
    task automatic check_flags();
        for (int d = 0; d < 2; d++) begin
            chk("full_n", d, 64'(full_n[d]), 64'(mcnt[d] != DEPTH));
            chk("almost_full", d, 64'(af[d]), 64'((DEPTH - mcnt[d]) <= AFM));
            chk("empty_n", d, 64'(empty_n[d]), 64'(d == 1 ? mov[d] : (mcnt[d] != 0)));
            chk("num_data_valid", d, 64'(num[d]), 64'(mcnt[d] + int'(mov[d])));
        end
    endtask

    // One clock: drive inputs, decide accept/pop from the model, advance the model at the edge.
    task automatic cycle(input bit rst_i, input bit w_i, input bit wce_i,
                         input bit r_i, input bit rce_i, input logic [DW-1:0] d_i);
        bit wf [2];
        bit rf [2];
        bit pop;
        reset = rst_i; w = w_i; wce = wce_i; r = r_i; rce = rce_i; din = d_i;
        for (int d = 0; d < 2; d++) begin
            wf[d] = w_i && wce_i && (mcnt[d] != DEPTH);
            rf[d] = r_i && rce_i && (d == 1 ? mov[d] : (mcnt[d] != 0));
        end
        if (!rst_i && wf[0]) exp0.push_back(d_i);
        if (!rst_i && wf[1]) exp1.push_back(d_i);
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rst_i) begin
                mcnt[d] = 0;
                mov[d]  = 1'b0;
            end else begin
                if (d == 1) begin
                    pop = (mcnt[d] != 0) && (!mov[d] || rf[d]);
                    if (pop) mov[d] = 1'b1;
                    else if (rf[d]) mov[d] = 1'b0;
                end else begin
                    pop = rf[d];
                end
                mcnt[d] = mcnt[d] + int'(wf[d]) - int'(pop);
            end
        end
        if (rst_i) begin
            exp0.delete();
            exp1.delete();
        end
        #1;
        check_flags();
    endtask

    // Monitor: whenever an instance hands out a word, it must be the oldest accepted one.
    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (empty_n[0] === 1'b1 && r && rce) begin
            if (exp0.size() == 0) chk("pop_unexpected", 0, 64'(dout[0]), 64'hDEAD_0000_0000);
            else begin
                e = exp0.pop_front();
                chk("dout", 0, 64'(dout[0]), 64'(e));
            end
        end
        if (empty_n[1] === 1'b1 && r && rce) begin
            if (exp1.size() == 0) chk("pop_unexpected", 1, 64'(dout[1]), 64'hDEAD_0000_0000);
            else begin
                e = exp1.pop_front();
                chk("dout", 1, 64'(dout[1]), 64'(e));
            end
        end
    end

    initial begin
        int pw, pr;
        mcnt[0] = 0; mcnt[1] = 0; mov[0] = 1'b0; mov[1] = 1'b0;

        cycle(1, 0, 0, 0, 0, '0);
        cycle(1, 0, 0, 0, 0, '0);
        for (int d = 0; d < 2; d++) begin
            chk("reset_num", d, 64'(num[d]), 64'd0);
            chk("reset_empty_n", d, 64'(empty_n[d]), 64'd0);
            chk("reset_full_n", d, 64'(full_n[d]), 64'd1);
            chk("reset_almost_full", d, 64'(af[d]), 64'd0);
        end
        chk("reset_dout", 1, 64'(dout[1]), 64'd0);

        // Fill with 0x00..0x0F, then offer 0xFF and 0xFE.
        for (int i = 0; i < DEPTH; i++) cycle(0, 1, 1, 0, 1, DW'(i));
        chk("fill_almost_full", 0, 64'(af[0]), 64'd1);
        cycle(0, 1, 1, 0, 1, 32'hFF);
        cycle(0, 1, 1, 0, 1, 32'hFE);
        chk("full_num", 0, 64'(num[0]), 64'd16);
        chk("full_num", 1, 64'(num[1]), 64'd17);
        chk("full_full_n", 0, 64'(full_n[0]), 64'd0);

        // Drain one per cycle.
        for (int i = 0; i < DEPTH + 2; i++) cycle(0, 0, 1, 1, 1, '0);
        chk("drained_num", 0, 64'(num[0]), 64'd0);
        chk("drained_num", 1, 64'(num[1]), 64'd0);

        // Hold five entries under continuous write+read.
        for (int i = 0; i < 5; i++) cycle(0, 1, 1, 0, 1, 32'hA0 + DW'(i));
        for (int i = 0; i < 20; i++) cycle(0, 1, 1, 1, 1, 32'hAA00 + DW'(i));
        chk("steady_num", 0, 64'(num[0]), 64'd5);
        chk("steady_num", 1, 64'(num[1]), 64'd5);
        for (int i = 0; i < 6; i++) cycle(0, 0, 1, 1, 1, '0);

        // Full plus simultaneous write+read: write refused for the combinational instance.
        for (int i = 0; i < DEPTH; i++) cycle(0, 1, 1, 0, 1, 32'hB0 + DW'(i));
        cycle(0, 1, 1, 1, 1, 32'hBEEF);
        chk("full_wr_rd_num", 0, 64'(num[0]), 64'd15);
        for (int i = 0; i < 6; i++) cycle(0, 0, 1, 1, 1, '0);
        chk("pre_reset_num", 0, 64'(num[0]), 64'd9);
        cycle(1, 1, 1, 1, 1, 32'hC0C0);
        for (int d = 0; d < 2; d++) begin
            chk("midreset_num", d, 64'(num[d]), 64'd0);
            chk("midreset_empty_n", d, 64'(empty_n[d]), 64'd0);
            chk("midreset_full_n", d, 64'(full_n[d]), 64'd1);
        end

        // Registered-output latency.
        cycle(0, 1, 1, 0, 1, 32'h5A);
        chk("lat_empty_n_k", 0, 64'(empty_n[0]), 64'd1);
        chk("lat_empty_n_k", 1, 64'(empty_n[1]), 64'd0);
        chk("lat_num_k", 1, 64'(num[1]), 64'd1);
        cycle(0, 0, 1, 0, 1, '0);
        chk("lat_empty_n_k1", 1, 64'(empty_n[1]), 64'd1);
        chk("lat_dout_k1", 1, 64'(dout[1]), 64'h5A);
        cycle(0, 0, 1, 1, 1, '0);
        chk("lat_read_empty", 1, 64'(empty_n[1]), 64'd0);

        // Random phases biased towards full, towards empty, then balanced.
        for (int ph = 0; ph < 3; ph++) begin
            pw = (ph == 0) ? 75 : (ph == 1) ? 30 : 50;
            pr = (ph == 0) ? 30 : (ph == 1) ? 75 : 50;
            for (int i = 0; i < 3400; i++) begin
                cycle(($urandom_range(0, 599) == 0),
                      ($urandom_range(0, 99) < pw), ($urandom_range(0, 99) < 90),
                      ($urandom_range(0, 99) < pr), ($urandom_range(0, 99) < 90),
                      DW'($urandom));
            end
        end
        for (int i = 0; i < DEPTH + 3; i++) cycle(0, 0, 1, 1, 1, '0);
        chk("final_num", 0, 64'(num[0]), 64'd0);
        chk("final_num", 1, 64'(num[1]), 64'd0);
        chk("scoreboard_left", 0, 64'(exp0.size()), 64'd0);
        chk("scoreboard_left", 1, 64'(exp1.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
